spi_target: RTL and testbench
=============================

SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of flip-flops in each SPI input synchronizer (minimum 2).
REQ-002 CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-003 nRESET  input  1  asynchronous, active-low reset.
REQ-004 SCK  input  1  SPI clock from the Gigatron bit-banged master, mode 0 (idle low).
REQ-005 MOSI  input  1  master-out data, MSB first.
REQ-006 nSS  input  1  active-low target select.
REQ-007 MISO  output  1  target-out data, MSB first.
REQ-008 MISO_OE  output  1  high while MISO is to be driven onto the shared line.
REQ-009 STATUS  input  8  status byte, shifted out during the command byte.
REQ-010 WADDR  output  4  write register address.
REQ-011 WDATA  output  8  write data.
REQ-012 WSTB  output  1  one-CLK write strobe.
REQ-013 RADDR  output  4  read register address.
REQ-014 RDATA  input  8  read data, valid one CLK after RADDR changes.
REQ-015 RSTB  output  1  one-CLK pulse when RDATA is captured (FIFO pop).

Function
REQ-016 SCK, MOSI and nSS SHALL each pass through SYNC_STAGES flip-flops; edges SHALL be detected on the synchronized signals only.
REQ-017 Legal SCK high and low phases SHALL be at least SYNC_STAGES+2 CLK each; shorter phases are unsupported.
REQ-018 The state machine SHALL have the states IDLE, CMD, WR, RD and IGN.
REQ-019 A synchronized nSS fall SHALL capture STATUS into the shift register, clear the 3-bit bit counter, assert MISO_OE and enter CMD.
REQ-020 A rising SCK SHALL shift MOSI into the receive register; a falling SCK SHALL shift the next transmit bit onto MISO.
REQ-021 When the bit counter wraps from 7 to 0, the byte SHALL be complete.
REQ-022 Command byte format: bit 7 = 1 write, 0 read; bits 6:4 SHALL be zero; bits 3:0 = start address.
REQ-023 Command with bits 6:4 nonzero: enter IGN; MISO = 0, no strobes until nSS rises.
REQ-024 Write command: load the address counter and enter WR; each complete data byte SHALL drive WDATA and WADDR and pulse WSTB for exactly one CLK, 1 CLK after byte completion; then the address SHALL increment.
REQ-025 Read command: load the address, drive RADDR, and enter RD.
REQ-026 One CLK after RADDR becomes valid, RDATA SHALL be loaded into the transmit register, RSTB SHALL pulse once, and the address SHALL increment.
REQ-027 In RD, each completed byte SHALL trigger the next RADDR/RDATA/RSTB sequence, finishing before the next falling SCK.
REQ-028 The address counter SHALL wrap from 15 to 0.
REQ-029 Bytes received in RD SHALL be discarded.
REQ-030 A synchronized nSS rise in any state SHALL return to IDLE, deassert MISO_OE, drive MISO to 0 and discard any partial byte with no strobe.
REQ-031 If a byte completes on the same CLK as the nSS rise, the nSS rise SHALL take priority and no strobe SHALL issue.
REQ-032 SCK edges while nSS is high SHALL be ignored.

Reset
REQ-033 nRESET low SHALL force: state IDLE; MISO 0; MISO_OE 0; WSTB 0; RSTB 0; WADDR 0; WDATA 0; RADDR 0; counters 0; synchronizers to their idle values (SCK 0, nSS 1, MOSI 0).
REQ-034 Reset asserted mid-transfer SHALL abort the transfer; after release, the block SHALL wait for a fresh nSS fall.

Structure
REQ-035 State encodings and the command field positions (write bit, reserved mask 0x70, address mask 0x0F) SHALL live in a shared package, spi_target_pkg.
REQ-036 The input synchronizer plus edge detector SHALL be one sub-module, spi_sync_edge, instantiated for SCK and nSS; MOSI uses the synchronizer only.

Verification
REQ-037 Write burst: nSS low, bytes 0x83, 0x11, 0x22 -> WSTB pulses exactly twice, with (WADDR 3, WDATA 0x11) then (4, 0x22).
REQ-038 Read with wrap: STATUS 0xA5, bytes 0x0F, 0x00, 0x00, with RDATA = 0x40|RADDR -> MISO bytes 0xA5, 0x4F, 0x40; RSTB pulses for RADDR 15 then 0; MISO_OE is high only while nSS is low.
REQ-039 Abort: write command 0x82, then 5 data bits, then nSS high -> no WSTB; MISO_OE 0 within SYNC_STAGES+2 CLK.
REQ-040 Reserved bits: command 0xF0 followed by 0x55 -> no WSTB or RSTB, MISO stays 0.
REQ-041 Reset mid-read: assert nRESET during the second byte of a read -> all outputs at reset values; next transfer 0x81, 0x7E -> WSTB with (1, 0x7E).
REQ-042 Noise: SCK toggles with nSS high, and the minimum legal SCK phase at SYNC_STAGES=2 and 3 -> no strobes while deselected; correct data at the minimum phase.

Source files
------------

// File: rtl/spi_target_pkg.sv
// Shared definitions for the SPI target: FSM state encoding and the
// command byte field layout (write flag, reserved bits, start address).
package spi_target_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_WR   = 3'd2,
    ST_RD   = 3'd3,
    ST_IGN  = 3'd4
  } state_t;

  localparam int         CMD_WR_BIT    = 7;
  localparam logic [7:0] CMD_RSV_MASK  = 8'h70;
  localparam logic [7:0] CMD_ADDR_MASK = 8'h0F;

  // State the command byte sends the FSM to once it has been received.
  function automatic state_t cmd_decode(input logic [7:0] cmd);
    if ((cmd & CMD_RSV_MASK) != 8'h00) return ST_IGN;
    else if (cmd[CMD_WR_BIT])          return ST_WR;
    else                               return ST_RD;
  endfunction

  function automatic logic [3:0] cmd_addr(input logic [7:0] cmd);
    return 4'(cmd & CMD_ADDR_MASK);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Input synchronizer with edge detection on the synchronized level.
// Ports:
//   CLK, nRESET  system clock, async active-low reset
//   din          asynchronous input
//   rise, fall   one-CLK pulses on synchronized rising / falling edges
// IDLE_VAL is the level the chain resets to, so no spurious edge is
// reported when reset releases with the line at its idle level.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_VAL    = 1'b0
) (
  input  logic CLK,
  input  logic nRESET,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   q_d;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      chain <= {SYNC_STAGES{IDLE_VAL}};
      q_d   <= IDLE_VAL;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      q_d   <= chain[SYNC_STAGES-1];
    end
  end

  assign rise = chain[SYNC_STAGES-1] & ~q_d;
  assign fall = ~chain[SYNC_STAGES-1] & q_d;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target bridging a bit-banged master to a 16-entry register
// space. The first byte is a command (bit 7 write, bits 3:0 start
// address); following bytes are written out or read back with an
// auto-incrementing, wrapping address. STATUS is shifted out during the
// command byte.
// Ports:
//   CLK, nRESET            system clock, async active-low reset
//   SCK, MOSI, nSS         SPI inputs (asynchronous)
//   MISO, MISO_OE          SPI output and its drive enable
//   STATUS                 byte returned during the command byte
//   WADDR, WDATA, WSTB     write port, WSTB one CLK wide
//   RADDR, RDATA, RSTB     read port, RSTB marks the RDATA capture
//
// state | meaning
// IDLE  | deselected, waiting for nSS fall
// CMD   | receiving command byte, shifting out STATUS
// WR    | receiving write data bytes
// RD    | shifting out read data, received bytes dropped
// IGN   | reserved command bits set, ignore until nSS rises
module spi_target
  import spi_target_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       SCK,
  input  logic       MOSI,
  input  logic       nSS,
  output logic       MISO,
  output logic       MISO_OE,
  input  logic [7:0] STATUS,
  output logic [3:0] WADDR,
  output logic [7:0] WDATA,
  output logic       WSTB,
  output logic [3:0] RADDR,
  input  logic [7:0] RDATA,
  output logic       RSTB
);

  logic sck_rise, sck_fall, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_chain;
  logic mosi_s;

  state_t     state, state_nxt;
  logic [2:0] bit_cnt;
  logic [6:0] rx_sr;
  logic [7:0] rx_byte, tx_sr;
  logic [3:0] addr;
  logic       rd_pend;
  logic       byte_done;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sck (
    .CLK(CLK), .nRESET(nRESET), .din(SCK), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_nss (
    .CLK(CLK), .nRESET(nRESET), .din(nSS), .rise(ss_rise), .fall(ss_fall)
  );

  // Same depth as the SCK chain so MOSI lines up with the detected edge.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) mosi_chain <= '0;
    else         mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], MOSI};
  end
  assign mosi_s = mosi_chain[SYNC_STAGES-1];

  assign rx_byte = {rx_sr, mosi_s};
  // Deselect wins over a byte completing on the same CLK.
  assign byte_done = (state != ST_IDLE) && sck_rise && (bit_cnt == 3'd7) && !ss_rise;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (ss_rise) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (ss_fall)   state_nxt = ST_CMD;
        ST_CMD:  if (byte_done) state_nxt = cmd_decode(rx_byte);
        default: ;
      endcase
    end
  end

  always_comb begin
    MISO_OE = 1'b0;
    MISO    = 1'b0;
    case (state)
      ST_CMD, ST_WR, ST_RD: begin
        MISO_OE = 1'b1;
        MISO    = tx_sr[7];
      end
      ST_IGN:  MISO_OE = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      bit_cnt <= '0;
      rx_sr   <= '0;
      tx_sr   <= '0;
      addr    <= '0;
      rd_pend <= 1'b0;
      WSTB    <= 1'b0;
      RSTB    <= 1'b0;
      WADDR   <= '0;
      WDATA   <= '0;
      RADDR   <= '0;
    end else begin
      WSTB <= 1'b0;
      RSTB <= 1'b0;
      if (ss_rise) begin
        bit_cnt <= '0;
        rd_pend <= 1'b0;
      end else if (state == ST_IDLE) begin
        if (ss_fall) begin
          tx_sr   <= STATUS;
          bit_cnt <= '0;
        end
      end else begin
        if (sck_rise) begin
          rx_sr   <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
        end
        // The fall right after a byte boundary keeps the freshly loaded
        // bit 7 on MISO instead of shifting it away.
        if (sck_fall && (bit_cnt != 3'd0)) tx_sr <= {tx_sr[6:0], 1'b0};
        if (byte_done) begin
          tx_sr <= '0;
          case (state)
            ST_CMD: begin
              addr <= cmd_addr(rx_byte);
              if (cmd_decode(rx_byte) == ST_RD) begin
                RADDR   <= cmd_addr(rx_byte);
                rd_pend <= 1'b1;
              end
            end
            ST_WR: begin
              WSTB  <= 1'b1;
              WDATA <= rx_byte;
              WADDR <= addr;
              addr  <= addr + 4'd1;
            end
            ST_RD: begin
              RADDR   <= addr;
              rd_pend <= 1'b1;
            end
            default: ;
          endcase
        end
        // RDATA has had one CLK to settle after RADDR moved.
        if (rd_pend) begin
          tx_sr   <= RDATA;
          RSTB    <= 1'b1;
          addr    <= addr + 4'd1;
          rd_pend <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_target.sv
module tb_spi_target;

  logic CLK = 1'b0, nRESET = 1'b0, SCK = 1'b0, MOSI = 1'b0, nSS = 1'b1;
  logic [7:0] STATUS = 8'h00;

  logic       miso [2], oe [2], wstb [2], rstb [2];
  logic [3:0] waddr [2], raddr [2];
  logic [7:0] wdata [2], rdata [2];

  always #5 CLK = ~CLK;

  spi_target #(.SYNC_STAGES(2)) dut2 (
    .CLK(CLK), .nRESET(nRESET), .SCK(SCK), .MOSI(MOSI), .nSS(nSS),
    .MISO(miso[0]), .MISO_OE(oe[0]), .STATUS(STATUS),
    .WADDR(waddr[0]), .WDATA(wdata[0]), .WSTB(wstb[0]),
    .RADDR(raddr[0]), .RDATA(rdata[0]), .RSTB(rstb[0])
  );

  spi_target #(.SYNC_STAGES(3)) dut3 (
    .CLK(CLK), .nRESET(nRESET), .SCK(SCK), .MOSI(MOSI), .nSS(nSS),
    .MISO(miso[1]), .MISO_OE(oe[1]), .STATUS(STATUS),
    .WADDR(waddr[1]), .WDATA(wdata[1]), .WSTB(wstb[1]),
    .RADDR(raddr[1]), .RDATA(rdata[1]), .RSTB(rstb[1])
  );

  assign rdata[0] = 8'h40 | {4'h0, raddr[0]};
  assign rdata[1] = 8'h40 | {4'h0, raddr[1]};

  int vectors = 0, errors = 0;
  int half = 5;
  logic en [2] = '{1'b1, 1'b1};

  // model expectations
  logic [7:0] txb [8];
  int wexp [16], rexp [16];
  int wexp_n = 0, rexp_n = 0;
  logic [7:0] mexp [8];
  logic mexp_v [8];
  // observations
  int whd [2] = '{0, 0}, rhd [2] = '{0, 0};
  int obs_w [2][16], obs_r [2][16];
  logic [7:0] cap [2][8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Expected behaviour of a transfer in which nfull bytes complete.
  task automatic model(input int nfull);
    int a;
    wexp_n = 0;
    rexp_n = 0;
    for (int i = 0; i < 8; i++) mexp_v[i] = 1'b0;
    mexp[0] = STATUS;
    mexp_v[0] = 1'b1;
    a = int'(txb[0][3:0]);
    if ((txb[0] & 8'h70) != 8'h00) begin
      for (int i = 1; i < 8; i++) begin mexp[i] = 8'h00; mexp_v[i] = 1'b1; end
    end else if (txb[0][7]) begin
      for (int i = 1; i < nfull; i++) begin
        wexp[wexp_n] = (a << 8) | int'(txb[i]);
        wexp_n++;
        a = (a + 1) % 16;
      end
    end else begin
      for (int i = 0; i < nfull; i++) begin
        rexp[rexp_n] = a;
        rexp_n++;
        if (i + 1 < 8) begin mexp[i+1] = 8'h40 | 8'(a); mexp_v[i+1] = 1'b1; end
        a = (a + 1) % 16;
      end
    end
  endtask

  task automatic clear_obs();
    for (int k = 0; k < 2; k++) begin
      whd[k] = 0;
      rhd[k] = 0;
      for (int i = 0; i < 8; i++) cap[k][i] = 8'h00;
    end
  endtask

  task automatic spi_bit(input logic b, input int bi);
    MOSI = b;
    wait_clk(half);
    for (int k = 0; k < 2; k++) cap[k][bi] = {cap[k][bi][6:0], miso[k]};
    SCK = 1'b1;
    wait_clk(half);
    SCK = 1'b0;
  endtask

  task automatic xfer(input int nbytes, input int extra_bits);
    clear_obs();
    nSS = 1'b0;
    wait_clk(8);
    for (int i = 0; i < nbytes; i++)
      for (int j = 7; j >= 0; j--) spi_bit(txb[i][j], i);
    for (int j = 0; j < extra_bits; j++) spi_bit(txb[nbytes][7-j], nbytes);
    wait_clk(8);
    nSS = 1'b1;
    wait_clk(12);
  endtask

  task automatic post_check(input int nfull);
    for (int k = 0; k < 2; k++) begin
      if (en[k]) begin
        check("wstb_count", whd[k], wexp_n);
        check("rstb_count", rhd[k], rexp_n);
        for (int i = 0; i < nfull; i++)
          if (mexp_v[i]) check("miso_byte", {24'd0, cap[k][i]}, {24'd0, mexp[i]});
      end
    end
  endtask

  // Per-cycle comparison against the model.
  logic nss_prev = 1'b1;
  int   stab = 0;
  always @(negedge CLK) begin
    if (nSS == nss_prev) stab++;
    else stab = 0;
    nss_prev = nSS;
    if (nRESET) begin
      for (int k = 0; k < 2; k++) begin
        if (en[k]) begin
          // SYNC_STAGES is k+2; MISO_OE must follow nSS within SYNC_STAGES+2 CLK.
          if (stab >= k + 4) begin
            check("miso_oe", {31'd0, oe[k]}, {31'd0, !nSS});
            if (nSS) check("miso_idle", {31'd0, miso[k]}, 32'd0);
          end
          if (wstb[k]) begin
            if (whd[k] < wexp_n) check("wstb_addr_data", {20'd0, waddr[k], wdata[k]}, wexp[whd[k]]);
            else check("wstb_extra", {31'd0, wstb[k]}, 32'd0);
            if (whd[k] < 16) obs_w[k][whd[k]] = int'({waddr[k], wdata[k]});
            whd[k]++;
          end
          if (rstb[k]) begin
            if (rhd[k] < rexp_n) check("rstb_raddr", {28'd0, raddr[k]}, rexp[rhd[k]]);
            else check("rstb_extra", {31'd0, rstb[k]}, 32'd0);
            if (rhd[k] < 16) obs_r[k][rhd[k]] = int'(raddr[k]);
            rhd[k]++;
          end
        end
      end
    end
  end

  task automatic check_reset_outputs();
    for (int k = 0; k < 2; k++) begin
      check("rst_miso", {31'd0, miso[k]}, 32'd0);
      check("rst_oe", {31'd0, oe[k]}, 32'd0);
      check("rst_wstb", {31'd0, wstb[k]}, 32'd0);
      check("rst_rstb", {31'd0, rstb[k]}, 32'd0);
      check("rst_waddr", {28'd0, waddr[k]}, 32'd0);
      check("rst_wdata", {24'd0, wdata[k]}, 32'd0);
      check("rst_raddr", {28'd0, raddr[k]}, 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_clk(3);
    check_reset_outputs();
    nRESET = 1'b1;
    wait_clk(10);

    // write burst
    STATUS = 8'h5C;
    txb[0] = 8'h83; txb[1] = 8'h11; txb[2] = 8'h22;
    model(3);
    xfer(3, 0);
    post_check(3);
    check("burst_n", whd[0], 2);
    check("burst_w0", obs_w[0][0], 32'h311);
    check("burst_w1", obs_w[0][1], 32'h422);

    // read with address wrap
    STATUS = 8'hA5;
    txb[0] = 8'h0F; txb[1] = 8'h00; txb[2] = 8'h00;
    model(3);
    xfer(3, 0);
    post_check(3);
    check("rd_b0", {24'd0, cap[0][0]}, 32'hA5);
    check("rd_b1", {24'd0, cap[0][1]}, 32'h4F);
    check("rd_b2", {24'd0, cap[0][2]}, 32'h40);
    check("rd_r0", obs_r[0][0], 32'd15);
    check("rd_r1", obs_r[0][1], 32'd0);

    // abort mid data byte
    STATUS = 8'h12;
    txb[0] = 8'h82; txb[1] = 8'hFF;
    model(1);
    xfer(1, 5);
    post_check(1);

    // reserved command bits
    STATUS = 8'h3C;
    txb[0] = 8'hF0; txb[1] = 8'h55;
    model(2);
    xfer(2, 0);
    post_check(2);
    check("ign_b1", {24'd0, cap[0][1]}, 32'h00);

    // reset during the second byte of a read
    STATUS = 8'h99;
    txb[0] = 8'h05; txb[1] = 8'h00;
    model(1);
    clear_obs();
    nSS = 1'b0;
    wait_clk(8);
    for (int j = 7; j >= 0; j--) spi_bit(txb[0][j], 0);
    for (int j = 0; j < 3; j++) spi_bit(1'b0, 1);
    wait_clk(2);
    nRESET = 1'b0;
    wait_clk(2);
    check_reset_outputs();
    nSS = 1'b1;
    wait_clk(6);
    nRESET = 1'b1;
    wait_clk(12);
    post_check(1);

    // fresh transfer after reset
    STATUS = 8'h00;
    txb[0] = 8'h81; txb[1] = 8'h7E;
    model(2);
    xfer(2, 0);
    post_check(2);
    check("post_rst_w", obs_w[0][0], 32'h17E);

    // SCK noise while deselected
    wexp_n = 0;
    rexp_n = 0;
    clear_obs();
    for (int i = 0; i < 12; i++) begin
      MOSI = 1'($urandom_range(0, 1));
      SCK = 1'b1; wait_clk(2);
      SCK = 1'b0; wait_clk(2);
    end
    wait_clk(10);
    post_check(0);

    // minimum legal phase for SYNC_STAGES=2 (already 5 CLK, the SYNC_STAGES=3 minimum, above)
    half = 4;
    en[1] = 1'b0;
    STATUS = 8'hC7;
    txb[0] = 8'h8E; txb[1] = 8'h5A; txb[2] = 8'hC3; txb[3] = 8'h99;
    model(4);
    xfer(4, 0);
    post_check(4);
    check("min_w2", obs_w[0][2], 32'h099);
    txb[0] = 8'h0E; txb[1] = 8'h00; txb[2] = 8'h00;
    model(3);
    xfer(3, 0);
    post_check(3);
    en[1] = 1'b1;
    half = 5;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
